rob_retire: RTL and testbench
=============================

ROB_RETIRE -- requirements
Module: rob_retire

Interface
REQ-001 Parameter ROB_DEPTH, default 16, number of reorder-buffer entries; power of two, 4..64.
REQ-002 Parameter IDX_W, default 4, entry-index width; equals log2(ROB_DEPTH).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 alloc_valid  in  1  rename stage presents a renamed instruction (driven by rename_valid).
REQ-006 alloc_phys_rd  in  6  new destination physical register; 6'h3F = no destination.
REQ-007 alloc_old_phys_rd  in  6  previous mapping of rd, freed at retire; 6'h3F = none.
REQ-008 alloc_is_store  in  1  instruction has no destination register.
REQ-009 alloc_ready  out  1  entry available; high exactly when occupancy < ROB_DEPTH.
REQ-010 alloc_rob_idx  out  IDX_W  index the next accepted allocation is written to (current tail).
REQ-011 complete_valid  in  1  execution result written back.
REQ-012 complete_rob_idx  in  IDX_W  entry being completed.
REQ-013 retire_valid1 / retire_valid2  out  1 each  slot 1 / slot 2 frees a physical register this cycle.
REQ-014 retire_phys_reg1 / retire_phys_reg2  out  6 each  physical register to return to the free list.
REQ-015 rob_empty  out  1  occupancy == 0.

Function
REQ-016 Entries form a circular queue: head (oldest), tail (next free), occupancy count 0..ROB_DEPTH; pointers wrap modulo ROB_DEPTH.
REQ-017 Each entry holds: valid, done, old_phys_rd, is_store.
REQ-018 Allocation: at a rising edge with alloc_valid && alloc_ready, entry[tail] is written valid=1, done=0, tail increments by 1.
REQ-019 alloc_valid while alloc_ready is low is dropped; no state changes; alloc_ready is computed from pre-edge occupancy, so a retire in the same cycle does not admit an allocation into a full buffer.
REQ-020 Completion: at a rising edge with complete_valid, entry[complete_rob_idx].done is set if that entry is valid; completion of an invalid entry is ignored; repeated completion is idempotent.
REQ-021 Completion and allocation targeting the same index in the same cycle: allocation wins; entry ends with done=0.
REQ-022 Retire selection (combinational from current state): slot 1 retires head if valid && done; slot 2 retires head+1 (wrapped) only if slot 1 retires and head+1 is valid && done; at most 2 entries per cycle, strictly in order.
REQ-023 On the edge, retired entries are cleared to valid=0, head advances by the number retired (0, 1 or 2), occupancy updates by +alloc -retired in the same edge.
REQ-024 retire_validN and retire_phys_regN are registered: set on the edge the entry retires, held one cycle; retire_validN=1 only if the retired entry has is_store=0 and old_phys_rd != 6'h3F; otherwise 0 (entry still retires).
REQ-025 retire_phys_regN = retired old_phys_rd when retire_validN=1, else 6'h3F.
REQ-026 Latency: entry completed at edge C retires at edge C+1 at earliest; retire outputs visible from C+1 to C+2.
REQ-027 Slot 2 never asserts while slot 1 is low in the same cycle.

Reset
REQ-028 While reset_n is low: head=0, tail=0, occupancy=0, all valid/done=0.
REQ-029 Reset outputs: alloc_ready=1, alloc_rob_idx=0, rob_empty=1, retire_valid1/2=0, retire_phys_reg1/2=6'h3F.
REQ-030 Reset asserted mid-operation discards all in-flight entries with no retire pulses generated.

Configuration
REQ-031 Macro ROB_DUAL_COMPLETE_EN: defined adds ports complete2_valid (in, 1) and complete2_rob_idx (in, IDX_W) with REQ-020/021 semantics; both ports same index same cycle sets done once.
REQ-032 Without ROB_DUAL_COMPLETE_EN the second completion port does not exist; all other behaviour identical.

Verification
REQ-033 Reset, alloc 3 entries (old_phys_rd 5,6,7), complete idx 0,1,2 in one cycle each, -> retire_phys_reg1=5 then 6 then 7 on successive cycles, one entry per cycle in order (slot 1 only).
REQ-034 Alloc 2 (old 10,11), complete idx 1 then idx 0 -> nothing retires after idx 1; cycle after idx 0 completes, retire_phys_reg1=10 and retire_phys_reg2=11 together.
REQ-035 Fill 16 entries -> alloc_ready=0, 17th alloc_valid dropped, alloc_rob_idx stays 0; retire head while alloc_valid high -> alloc accepted next cycle at idx 0 (wrap).
REQ-036 Alloc store (is_store=1, old 6'h3F) at head, complete -> entry retires, head advances, retire_valid1=0, retire_phys_reg1=6'h3F.
REQ-037 Alloc 4, complete 2, assert reset_n=0 -> occupancy 0, rob_empty=1, no retire_valid pulses, next alloc_rob_idx=0.
REQ-038 ROB_DUAL_COMPLETE_EN defined: complete idx 0 and idx 1 via both ports same cycle -> both retire together next cycle.

Source files
------------

// File: rtl/rob_retire.sv
// rtl/rob_retire.sv - reorder buffer with in-order dual-slot retirement (option: ROB_DUAL_COMPLETE_EN)
module rob_retire #(
    parameter int ROB_DEPTH = 16,
    parameter int IDX_W     = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             alloc_valid,
    input  logic [5:0]       alloc_phys_rd,
    input  logic [5:0]       alloc_old_phys_rd,
    input  logic             alloc_is_store,
    output logic             alloc_ready,
    output logic [IDX_W-1:0] alloc_rob_idx,
    input  logic             complete_valid,
    input  logic [IDX_W-1:0] complete_rob_idx,
`ifdef ROB_DUAL_COMPLETE_EN
    input  logic             complete2_valid,
    input  logic [IDX_W-1:0] complete2_rob_idx,
`endif
    output logic             retire_valid1,
    output logic             retire_valid2,
    output logic [5:0]       retire_phys_reg1,
    output logic [5:0]       retire_phys_reg2,
    output logic             rob_empty
);

    localparam logic [5:0]     NO_REG   = 6'h3F;
    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(ROB_DEPTH);

    // Per-entry state
    logic [ROB_DEPTH-1:0] valid_q, valid_d;
    logic [ROB_DEPTH-1:0] done_q, done_d;
    logic [ROB_DEPTH-1:0] store_q, store_d;
    logic [5:0]           old_q [ROB_DEPTH];
    logic [5:0]           old_d [ROB_DEPTH];

    // Queue pointers and occupancy
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [IDX_W:0]   count_q, count_d;

    // Registered retire outputs
    logic       retire_valid1_q, retire_valid1_d;
    logic       retire_valid2_q, retire_valid2_d;
    logic [5:0] retire_phys_reg1_q, retire_phys_reg1_d;
    logic [5:0] retire_phys_reg2_q, retire_phys_reg2_d;

    logic [IDX_W-1:0] head_p1;
    logic             alloc_fire;
    logic             ret1;
    logic             ret2;

    // The new destination register is tracked by rename, not by the ROB
    logic unused_alloc_phys_rd;
    assign unused_alloc_phys_rd = ^alloc_phys_rd;

    assign alloc_ready   = (count_q != FULL_CNT);
    assign alloc_rob_idx = tail_q;
    assign rob_empty     = (count_q == '0);
    assign alloc_fire    = alloc_valid && alloc_ready;
    assign head_p1       = head_q + IDX_W'(1);

    assign retire_valid1    = retire_valid1_q;
    assign retire_valid2    = retire_valid2_q;
    assign retire_phys_reg1 = retire_phys_reg1_q;
    assign retire_phys_reg2 = retire_phys_reg2_q;

    // Retire selection: slot 2 only follows a retiring slot 1, keeping strict order
    always_comb begin
        ret1 = valid_q[head_q] && done_q[head_q];
        ret2 = ret1 && valid_q[head_p1] && done_q[head_p1];
    end

    // Next entry state: completion, then retire clear, then allocation (allocation wins)
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        store_d = store_q;
        old_d   = old_q;
        if (complete_valid && valid_q[complete_rob_idx]) begin
            done_d[complete_rob_idx] = 1'b1;
        end
`ifdef ROB_DUAL_COMPLETE_EN
        if (complete2_valid && valid_q[complete2_rob_idx]) begin
            done_d[complete2_rob_idx] = 1'b1;
        end
`endif
        if (ret1) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
        end
        if (ret2) begin
            valid_d[head_p1] = 1'b0;
            done_d[head_p1]  = 1'b0;
        end
        if (alloc_fire) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            store_d[tail_q] = alloc_is_store;
            old_d[tail_q]   = alloc_old_phys_rd;
        end
    end

    // Pointer and occupancy update
    always_comb begin
        head_d  = head_q + IDX_W'(ret1) + IDX_W'(ret2);
        tail_d  = tail_q + IDX_W'(alloc_fire);
        count_d = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(ret1) - (IDX_W+1)'(ret2);
    end

    // Free-list return: stores and entries without an old mapping retire silently
    always_comb begin
        retire_valid1_d    = ret1 && !store_q[head_q] && (old_q[head_q] != NO_REG);
        retire_valid2_d    = ret2 && !store_q[head_p1] && (old_q[head_p1] != NO_REG);
        retire_phys_reg1_d = retire_valid1_d ? old_q[head_q] : NO_REG;
        retire_phys_reg2_d = retire_valid2_d ? old_q[head_p1] : NO_REG;
    end

    // State registers; reset discards every in-flight entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q            <= '0;
            done_q             <= '0;
            store_q            <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                old_q[i] <= NO_REG;
            end
            head_q             <= '0;
            tail_q             <= '0;
            count_q            <= '0;
            retire_valid1_q    <= 1'b0;
            retire_valid2_q    <= 1'b0;
            retire_phys_reg1_q <= NO_REG;
            retire_phys_reg2_q <= NO_REG;
        end else begin
            valid_q            <= valid_d;
            done_q             <= done_d;
            store_q            <= store_d;
            old_q              <= old_d;
            head_q             <= head_d;
            tail_q             <= tail_d;
            count_q            <= count_d;
            retire_valid1_q    <= retire_valid1_d;
            retire_valid2_q    <= retire_valid2_d;
            retire_phys_reg1_q <= retire_phys_reg1_d;
            retire_phys_reg2_q <= retire_phys_reg2_d;
        end
    end

endmodule

// File: tb/tb_rob_retire.sv
// tb/tb_rob_retire.sv - directed self-checking bench for rob_retire
module tb_rob_retire;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       alloc_valid;
    logic [5:0] alloc_phys_rd;
    logic [5:0] alloc_old_phys_rd;
    logic       alloc_is_store;
    logic       alloc_ready;
    logic [3:0] alloc_rob_idx;
    logic       complete_valid;
    logic [3:0] complete_rob_idx;
`ifdef ROB_DUAL_COMPLETE_EN
    logic       complete2_valid;
    logic [3:0] complete2_rob_idx;
`endif
    logic       retire_valid1;
    logic       retire_valid2;
    logic [5:0] retire_phys_reg1;
    logic [5:0] retire_phys_reg2;
    logic       rob_empty;

    int passed = 0;
    int total  = 0;

    rob_retire #(.ROB_DEPTH(16), .IDX_W(4)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .alloc_valid       (alloc_valid),
        .alloc_phys_rd     (alloc_phys_rd),
        .alloc_old_phys_rd (alloc_old_phys_rd),
        .alloc_is_store    (alloc_is_store),
        .alloc_ready       (alloc_ready),
        .alloc_rob_idx     (alloc_rob_idx),
        .complete_valid    (complete_valid),
        .complete_rob_idx  (complete_rob_idx),
`ifdef ROB_DUAL_COMPLETE_EN
        .complete2_valid   (complete2_valid),
        .complete2_rob_idx (complete2_rob_idx),
`endif
        .retire_valid1     (retire_valid1),
        .retire_valid2     (retire_valid2),
        .retire_phys_reg1  (retire_phys_reg1),
        .retire_phys_reg2  (retire_phys_reg2),
        .rob_empty         (rob_empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_ret(input string tag, input logic v1, input logic [5:0] r1,
                           input logic v2, input logic [5:0] r2);
        chk({tag, "_v1"}, 32'(retire_valid1), 32'(v1));
        chk({tag, "_r1"}, 32'(retire_phys_reg1), 32'(r1));
        chk({tag, "_v2"}, 32'(retire_valid2), 32'(v2));
        chk({tag, "_r2"}, 32'(retire_phys_reg2), 32'(r2));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic alloc(input logic [5:0] old_rd, input logic st);
        alloc_valid       = 1'b1;
        alloc_old_phys_rd = old_rd;
        alloc_is_store    = st;
        tick();
        alloc_valid       = 1'b0;
        alloc_is_store    = 1'b0;
    endtask

    initial begin
        reset_n           = 1'b0;
        alloc_valid       = 1'b0;
        alloc_phys_rd     = 6'd1;
        alloc_old_phys_rd = 6'h3F;
        alloc_is_store    = 1'b0;
        complete_valid    = 1'b0;
        complete_rob_idx  = '0;
`ifdef ROB_DUAL_COMPLETE_EN
        complete2_valid   = 1'b0;
        complete2_rob_idx = '0;
`endif
        #1;
        tick();
        // reset state
        chk("rst_ready", 32'(alloc_ready), 32'd1);
        chk("rst_idx", 32'(alloc_rob_idx), 32'd0);
        chk("rst_empty", 32'(rob_empty), 32'd1);
        chk_ret("rst", 1'b0, 6'h3F, 1'b0, 6'h3F);
        reset_n = 1'b1;
        tick();

        // in-order single-slot retirement of 5, 6, 7
        alloc(6'd5, 1'b0);
        chk("a1_idx", 32'(alloc_rob_idx), 32'd1);
        chk("a1_empty", 32'(rob_empty), 32'd0);
        alloc(6'd6, 1'b0);
        alloc(6'd7, 1'b0);
        chk("a3_idx", 32'(alloc_rob_idx), 32'd3);
        complete_valid = 1'b1; complete_rob_idx = 4'd0;
        tick();
        chk_ret("c0", 1'b0, 6'h3F, 1'b0, 6'h3F);
        complete_rob_idx = 4'd1;
        tick();
        chk_ret("r5", 1'b1, 6'd5, 1'b0, 6'h3F);
        complete_rob_idx = 4'd2;
        tick();
        chk_ret("r6", 1'b1, 6'd6, 1'b0, 6'h3F);
        complete_valid = 1'b0;
        tick();
        chk_ret("r7", 1'b1, 6'd7, 1'b0, 6'h3F);
        chk("r7_empty", 32'(rob_empty), 32'd1);
        tick();
        chk_ret("idle", 1'b0, 6'h3F, 1'b0, 6'h3F);

        // out-of-order completion, dual retire (entries at idx 3, 4)
        alloc(6'd10, 1'b0);
        alloc(6'd11, 1'b0);
        complete_valid = 1'b1; complete_rob_idx = 4'd4;
        tick();
        complete_valid = 1'b0;
        tick();
        chk_ret("ooo_hold", 1'b0, 6'h3F, 1'b0, 6'h3F);
        complete_valid = 1'b1; complete_rob_idx = 4'd3;
        tick();
        complete_valid = 1'b0;
        chk_ret("ooo_c3", 1'b0, 6'h3F, 1'b0, 6'h3F);
        tick();
        chk_ret("dual", 1'b1, 6'd10, 1'b1, 6'd11);
        chk("dual_empty", 32'(rob_empty), 32'd1);

        // mid-operation reset (entries at idx 5..8)
        alloc(6'd20, 1'b0);
        alloc(6'd21, 1'b0);
        alloc(6'd22, 1'b0);
        alloc(6'd23, 1'b0);
        complete_valid = 1'b1; complete_rob_idx = 4'd5;
        tick();
        complete_rob_idx = 4'd6;
        tick();
        complete_valid = 1'b0;
        chk_ret("pre_rst", 1'b1, 6'd20, 1'b0, 6'h3F);
        reset_n = 1'b0;
        #1;
        chk("mrst_empty", 32'(rob_empty), 32'd1);
        chk("mrst_idx", 32'(alloc_rob_idx), 32'd0);
        chk_ret("mrst", 1'b0, 6'h3F, 1'b0, 6'h3F);
        tick();
        chk_ret("mrst_hold", 1'b0, 6'h3F, 1'b0, 6'h3F);
        reset_n = 1'b1;
        tick();
        chk_ret("post_rst", 1'b0, 6'h3F, 1'b0, 6'h3F);
        chk("post_rst_ready", 32'(alloc_ready), 32'd1);

        // fill to capacity, drop overflow, wrap after a retire
        for (int i = 0; i < 16; i++) begin
            alloc(6'(i + 1), 1'b0);
        end
        chk("full_ready", 32'(alloc_ready), 32'd0);
        chk("full_idx", 32'(alloc_rob_idx), 32'd0);
        chk("full_empty", 32'(rob_empty), 32'd0);
        alloc_valid = 1'b1; alloc_old_phys_rd = 6'd40;
        tick();
        chk("drop_idx", 32'(alloc_rob_idx), 32'd0);
        chk("drop_ready", 32'(alloc_ready), 32'd0);
        alloc_old_phys_rd = 6'd41;
        complete_valid = 1'b1; complete_rob_idx = 4'd0;
        tick();
        complete_valid = 1'b0;
        chk("cfull_ready", 32'(alloc_ready), 32'd0);
        tick();
        chk_ret("full_ret", 1'b1, 6'd1, 1'b0, 6'h3F);
        chk("same_edge_idx", 32'(alloc_rob_idx), 32'd0);
        chk("same_edge_ready", 32'(alloc_ready), 32'd1);
        tick();
        alloc_valid = 1'b0;
        chk("wrap_idx", 32'(alloc_rob_idx), 32'd1);
        chk("wrap_ready", 32'(alloc_ready), 32'd0);

        // stores retire silently but advance head
        do_reset();
        alloc(6'h3F, 1'b1);
        alloc(6'd12, 1'b1);
        alloc(6'd9, 1'b0);
        complete_valid = 1'b1; complete_rob_idx = 4'd0;
        tick();
        complete_valid = 1'b0;
        tick();
        chk_ret("store", 1'b0, 6'h3F, 1'b0, 6'h3F);
        complete_valid = 1'b1; complete_rob_idx = 4'd1;
        tick();
        complete_rob_idx = 4'd2;
        tick();
        complete_valid = 1'b0;
        chk_ret("store2", 1'b0, 6'h3F, 1'b0, 6'h3F);
        tick();
        chk_ret("after_store", 1'b1, 6'd9, 1'b0, 6'h3F);
        chk("store_empty", 32'(rob_empty), 32'd1);

        // completion of an unallocated entry is ignored (idx 3 not yet valid)
        complete_valid = 1'b1; complete_rob_idx = 4'd3;
        tick();
        complete_valid = 1'b0;
        alloc(6'd30, 1'b0);
        tick();
        chk_ret("inval_cmp", 1'b0, 6'h3F, 1'b0, 6'h3F);
        chk("inval_empty", 32'(rob_empty), 32'd0);

`ifdef ROB_DUAL_COMPLETE_EN
        // both completion ports in one cycle -> dual retire next edge
        do_reset();
        alloc(6'd13, 1'b0);
        alloc(6'd14, 1'b0);
        complete_valid  = 1'b1; complete_rob_idx  = 4'd0;
        complete2_valid = 1'b1; complete2_rob_idx = 4'd1;
        tick();
        complete_valid  = 1'b0;
        complete2_valid = 1'b0;
        tick();
        chk_ret("dual_port", 1'b1, 6'd13, 1'b1, 6'd14);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
